reg_to_uart: RTL and testbench

//  Transmit-side companion of the UART-to-register path: captures a register

---
 rtl/reg_to_uart.sv | 160 ++++++++++++++++
 tb/tb_reg_to_uart.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/reg_to_uart.sv
// reg_to_uart: captures a register word on a send request and serialises it as UART frames.
// Define REG_TO_UART_HEX_ASCII_EN to send the word as uppercase hex ASCII digits plus CR LF.
module reg_to_uart #(
    parameter int unsigned WORDSZ    = 8,
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned BIT_RATE  = 9_600,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [WORDSZ-1:0] bus,
    input  logic              send,
    output logic              uart_txd,
    output logic              busy,
    output logic              done
);
    localparam int unsigned CyclesPerBit = CLK_HZ / BIT_RATE;
    localparam int unsigned CntW         = $clog2(CyclesPerBit) + 1;
`ifdef REG_TO_UART_HEX_ASCII_EN
    localparam int unsigned Payload = 8;
    localparam int unsigned Digits  = (WORDSZ + 3) / 4;
    localparam int unsigned Frames  = Digits + 2;
`else
    localparam int unsigned Payload = WORDSZ;
    localparam int unsigned Frames  = 1;
`endif
    localparam int unsigned IdxW = $clog2(Payload);
    localparam int unsigned ChW  = $clog2(Frames + 1);

    localparam logic [CntW-1:0] CntLast  = CntW'(CyclesPerBit - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(Payload - 1);
    localparam logic [ChW-1:0]  CharLast = ChW'(Frames - 1);
    localparam logic            StopLast = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [ChW-1:0]    char_q, char_d;
    logic              stop_q, stop_d;
    logic [WORDSZ-1:0] shadow_q, shadow_d;
    logic              txd_q, txd_d;
    logic              done_q, done_d;
    logic [Payload-1:0] frame_bits;

`ifdef REG_TO_UART_HEX_ASCII_EN
    localparam int unsigned PadW = 4 * Digits;
    logic [PadW-1:0] padded;
    logic [3:0]      nibble;

    // Character for the current frame: hex digits MSB nibble first, then CR, LF.
    always_comb begin
        padded = PadW'(shadow_q);
        nibble = 4'h0;
        for (int i = 0; i < int'(Digits); i++) begin
            if (char_q == ChW'(i)) nibble = padded[4*(Digits-1-i) +: 4];
        end
        if (char_q == ChW'(Digits))          frame_bits = 8'h0D;
        else if (char_q == ChW'(Digits + 1)) frame_bits = 8'h0A;
        else if (nibble < 4'd10)             frame_bits = 8'h30 + {4'h0, nibble};
        else                                 frame_bits = 8'h37 + {4'h0, nibble};
    end
`else
    assign frame_bits = shadow_q;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        char_d   = char_q;
        stop_d   = stop_q;
        shadow_d = shadow_q;
        txd_d    = txd_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                txd_d = 1'b1;
                if (send) begin
                    shadow_d = bus;
                    char_d   = '0;
                    cnt_d    = '0;
                    txd_d    = 1'b0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    txd_d   = frame_bits[0];
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (idx_q == IdxLast) begin
                        stop_d  = 1'b0;
                        txd_d   = 1'b1;
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        txd_d = frame_bits[idx_d];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (stop_q != StopLast) begin
                        stop_d = 1'b1;
                    end else if (char_q != CharLast) begin
                        char_d  = char_q + 1'b1;
                        txd_d   = 1'b0;
                        state_d = StStart;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            char_q   <= '0;
            stop_q   <= 1'b0;
            shadow_q <= '0;
            txd_q    <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            char_q   <= char_d;
            stop_q   <= stop_d;
            shadow_q <= shadow_d;
            txd_q    <= txd_d;
            done_q   <= done_d;
        end
    end

    assign uart_txd = txd_q;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;

endmodule

// File: tb/tb_reg_to_uart.sv
// Self-checking bench for reg_to_uart: per-cycle line/busy/done checks against a frame model.
module tb_reg_to_uart;
    localparam int unsigned WORDSZ    = 8;
    localparam int unsigned CLK_HZ    = 1_000_000;
    localparam int unsigned BIT_RATE  = 100_000;
    localparam int unsigned STOP_BITS = 1;
    localparam int unsigned CPB       = CLK_HZ / BIT_RATE;
`ifdef REG_TO_UART_HEX_ASCII_EN
    localparam int unsigned PAYLOAD = 8;
`else
    localparam int unsigned PAYLOAD = WORDSZ;
`endif

    logic              clk;
    logic              resetn;
    logic [WORDSZ-1:0] bus;
    logic              send;
    logic              uart_txd;
    logic              busy;
    logic              done;

    int unsigned checks = 0;
    int unsigned passes = 0;
    bit          exp_line[$];

    reg_to_uart #(
        .WORDSZ   (WORDSZ),
        .CLK_HZ   (CLK_HZ),
        .BIT_RATE (BIT_RATE),
        .STOP_BITS(STOP_BITS)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .bus     (bus),
        .send    (send),
        .uart_txd(uart_txd),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected line level for every clock of the whole transmission.
    function automatic void build_line(input logic [WORDSZ-1:0] w);
        int unsigned bytes[$];
        int unsigned nib;
        exp_line.delete();
`ifdef REG_TO_UART_HEX_ASCII_EN
        for (int d = int'((WORDSZ + 3) / 4) - 1; d >= 0; d--) begin
            nib = (int'(w) >> (4 * d)) & 15;
            bytes.push_back(nib < 10 ? 48 + nib : 55 + nib);
        end
        bytes.push_back(13);
        bytes.push_back(10);
`else
        bytes.push_back(int'(w));
`endif
        foreach (bytes[i]) begin
            repeat (CPB) exp_line.push_back(1'b0);
            for (int b = 0; b < int'(PAYLOAD); b++)
                repeat (CPB) exp_line.push_back(bit'((bytes[i] >> b) & 1));
            repeat (CPB * STOP_BITS) exp_line.push_back(1'b1);
        end
    endfunction

    // Called at the negedge just after the accepting edge; ends at the done cycle.
    task automatic observe(input logic [WORDSZ-1:0] w, input bit disturb, input int stop_at);
        build_line(w);
        for (int c = 0; c < exp_line.size(); c++) begin
            if (c == stop_at) return;
            chk($sformatf("txd w=%0h c%0d", w, c), 32'(uart_txd), 32'(exp_line[c]));
            chk($sformatf("busy c%0d", c), 32'(busy), 32'd1);
            chk($sformatf("done c%0d", c), 32'(done), 32'd0);
            if (disturb && c == 35) begin
                bus  = WORDSZ'($urandom);
                send = 1'b1;
            end
            if (disturb && c == 36) send = 1'b0;
            @(negedge clk);
        end
        chk("done pulse", 32'(done), 32'd1);
        chk("busy at done", 32'(busy), 32'd0);
        chk("txd at done", 32'(uart_txd), 32'd1);
    endtask

    initial begin
        logic [WORDSZ-1:0] w;
        resetn = 1'b0;
        send   = 1'b0;
        bus    = '0;
        repeat (3) @(negedge clk);
        chk("rst txd", 32'(uart_txd), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        resetn = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("idle txd", 32'(uart_txd), 32'd1);
            chk("idle busy", 32'(busy), 32'd0);
        end

        // Single frame with a one-clock send pulse.
        bus  = WORDSZ'(8'hA5);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        observe(WORDSZ'(8'hA5), 1'b0, -1);
        @(negedge clk);
        chk("done cleared", 32'(done), 32'd0);

        // Send and bus change while busy must not disturb the frame.
        bus  = WORDSZ'(8'hA5);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        bus  = WORDSZ'(8'h3C);
        observe(WORDSZ'(8'hA5), 1'b1, -1);
        @(negedge clk);
        chk("ignored send", 32'(busy), 32'd0);

        // send held high: back-to-back frames with one idle clock between.
        bus  = '0;
        send = 1'b1;
        @(negedge clk);
        observe('0, 1'b0, -1);
        bus = '1;
        @(negedge clk);
        send = 1'b0;
        observe('1, 1'b0, -1);
        @(negedge clk);
        chk("b2b done cleared", 32'(done), 32'd0);
        chk("b2b idle", 32'(busy), 32'd0);

        // Reset during data bit 3 aborts the frame.
        w    = WORDSZ'($urandom);
        bus  = w;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        observe(w, 1'b0, 45);
        resetn = 1'b0;
        #1;
        chk("abort txd", 32'(uart_txd), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (30) begin
            @(negedge clk);
            chk("post-abort txd", 32'(uart_txd), 32'd1);
            chk("post-abort done", 32'(done), 32'd0);
            chk("post-abort busy", 32'(busy), 32'd0);
        end

        // Random words, some with mid-frame interference.
        for (int k = 0; k < 6; k++) begin
            w    = WORDSZ'($urandom);
            bus  = w;
            send = 1'b1;
            @(negedge clk);
            send = 1'b0;
            observe(w, k[0], -1);
            repeat (2) @(negedge clk);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
